// File: rtl/gf180mcu_osu_sc_invpipe_pkg.sv
// Shared constants and helpers for the inverting valid/ready pipeline.
package gf180mcu_osu_sc_invpipe_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;
   localparam int unsigned DEFAULT_DEPTH = 3;

   // Reset value of every polarity-mask bit: invert.
   localparam logic RST_MASK_BIT = 1'b1;

   function automatic int unsigned occ_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_gp9t3v3__invpipe_stage.sv
// One pipeline stage: valid bit plus data word, loaded whenever adv is high.
module gf180mcu_osu_sc_gp9t3v3__invpipe_stage
   import gf180mcu_osu_sc_invpipe_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             adv,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q,  data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (adv) begin
         valid_d = in_valid;
         data_d  = in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/gf180mcu_osu_sc_gp9t3v3__invpipe.sv
// Registered inverting pipeline with bubble-collapsing valid/ready flow and occupancy count.
// Define GF180_OSU_INVPIPE_POL_EN to add the loadable polarity mask (POL/POL_LD ports).
module gf180mcu_osu_sc_gp9t3v3__invpipe
   import gf180mcu_osu_sc_invpipe_pkg::*;
#(
   parameter  int unsigned WIDTH = DEFAULT_WIDTH,
   parameter  int unsigned DEPTH = DEFAULT_DEPTH,
   localparam int unsigned OCC_W = occ_width(DEPTH)
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic [WIDTH-1:0] A,
   input  logic             A_VALID,
   output logic             A_READY,
   output logic [WIDTH-1:0] Y,
   output logic             Y_VALID,
   input  logic             Y_READY,
   output logic [OCC_W-1:0] OCC
`ifdef GF180_OSU_INVPIPE_POL_EN
   ,
   input  logic             POL_LD,
   input  logic [WIDTH-1:0] POL
`endif
);

   logic [DEPTH-1:0] stg_valid;
   logic [WIDTH-1:0] stg_data [DEPTH];
   logic [DEPTH-1:0] adv_c;
   logic [WIDTH-1:0] mask;
   logic             in_xfer_c;
   logic             out_xfer_c;
   logic [OCC_W-1:0] occ_q, occ_d;

   // A stage advances if it or any stage downstream of it is empty, or Y_READY.
   always_comb begin : ready_chain
      logic run;
      run   = Y_READY;
      adv_c = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         run      = run | ~stg_valid[i];
         adv_c[i] = run;
      end
   end

`ifdef GF180_OSU_INVPIPE_POL_EN
   logic [WIDTH-1:0] mask_q, mask_d;

   always_comb begin
      mask_d = mask_q;
      if (POL_LD) mask_d = POL;
   end

   // Entry uses mask_q, so a word accepted on a load edge still sees the old mask.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) mask_q <= {WIDTH{RST_MASK_BIT}};
      else     mask_q <= mask_d;
   end

   assign mask = mask_q;
`else
   assign mask = {WIDTH{RST_MASK_BIT}};
`endif

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             in_valid;
      logic [WIDTH-1:0] in_data;

      if (i == 0) begin : g_head
         assign in_valid = A_VALID;
         assign in_data  = A ^ mask;
      end else begin : g_body
         assign in_valid = stg_valid[i-1];
         assign in_data  = stg_data[i-1];
      end

      gf180mcu_osu_sc_gp9t3v3__invpipe_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk      (CLK),
         .rst_n    (RN),
         .adv      (adv_c[i]),
         .in_valid (in_valid),
         .in_data  (in_data),
         .valid    (stg_valid[i]),
         .data     (stg_data[i])
      );
   end

   assign A_READY    = adv_c[0];
   assign Y          = stg_data[DEPTH-1];
   assign Y_VALID    = stg_valid[DEPTH-1];
   assign in_xfer_c  = A_VALID & A_READY;
   assign out_xfer_c = Y_VALID & Y_READY;

   // Occupancy tracks transfers rather than re-counting the valid bits.
   always_comb begin
      occ_d = occ_q;
      if (in_xfer_c && !out_xfer_c)      occ_d = occ_q + OCC_W'(1);
      else if (!in_xfer_c && out_xfer_c) occ_d = occ_q - OCC_W'(1);
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) occ_q <= '0;
      else     occ_q <= occ_d;
   end

   assign OCC = occ_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__invpipe.sv
// Scoreboard bench for the inverting pipeline: driver pushes expected words, monitor pops on output transfers.
module tb_gf180mcu_osu_sc_gp9t3v3__invpipe;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 3;
   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   typedef struct {
      logic [WIDTH-1:0] d;
      int               acc;
      bit               exact;
   } exp_t;

   logic             CLK = 1'b0;
   logic             RN;
   logic [WIDTH-1:0] A;
   logic             A_VALID;
   logic             A_READY;
   logic [WIDTH-1:0] Y;
   logic             Y_VALID;
   logic             Y_READY;
   logic [OCC_W-1:0] OCC;
   logic             pol_ld;
   logic [WIDTH-1:0] pol_v;

   exp_t             q[$];
   logic [WIDTH-1:0] mask_m;
   int               cyc = 0;
   int               n_cmp = 0;
   int               n_err = 0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   gf180mcu_osu_sc_gp9t3v3__invpipe #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .CLK     (CLK),
      .RN      (RN),
      .A       (A),
      .A_VALID (A_VALID),
      .A_READY (A_READY),
      .Y       (Y),
      .Y_VALID (Y_VALID),
      .Y_READY (Y_READY),
      .OCC     (OCC)
`ifdef GF180_OSU_INVPIPE_POL_EN
      ,
      .POL_LD  (pol_ld),
      .POL     (pol_v)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One bus cycle: drive after the falling edge, check handshake state, record accepted word.
   task automatic bus_cycle(input bit v, input logic [WIDTH-1:0] a, input bit yr,
                            input bit ld, input logic [WIDTH-1:0] pv, input bit exact,
                            output bit accepted);
      @(negedge CLK);
      A_VALID = v;
      A       = a;
      Y_READY = yr;
      pol_ld  = ld;
      pol_v   = pv;
      #1;
      check("occ", 32'(OCC), 32'(q.size()));
      check("a_ready", 32'(A_READY), 32'((q.size() < DEPTH) || yr));
      accepted = v && A_READY;
      if (accepted) q.push_back('{d: a ^ mask_m, acc: cyc, exact: exact});
`ifdef GF180_OSU_INVPIPE_POL_EN
      if (ld) mask_m = pv;
`endif
   endtask

   task automatic drain();
      bit acc;
      int n = 0;
      while (q.size() > 0 && n < 60) begin
         bus_cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, acc);
         n++;
      end
      check("drain_done", 32'(q.size()), 32'd0);
   endtask

   // Monitor: every output transfer must match the oldest outstanding word.
   always begin
      exp_t e;
      @(negedge CLK);
      #2;
      if (RN === 1'b1 && Y_VALID === 1'b1) begin
         if (q.size() == 0) begin
            check("y_unexpected", 32'(Y_VALID), 32'd0);
         end else if (Y_READY) begin
            e = q.pop_front();
            check("y_data", 32'(Y), 32'(e.d));
            if (e.exact) check("latency", 32'(cyc - e.acc), 32'(DEPTH));
            else         check("latency_min", 32'((cyc - e.acc) >= int'(DEPTH)), 32'd1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit               acc;
      int               idx;
      int               sent;
      int               t;
      logic [WIDTH-1:0] words [DEPTH+1];
      logic [WIDTH-1:0] seq [3];

      RN      = 1'b0;
      A       = '0;
      A_VALID = 1'b0;
      Y_READY = 1'b0;
      pol_ld  = 1'b0;
      pol_v   = '0;
      mask_m  = '1;

      repeat (2) @(negedge CLK);
      #1;
      check("rst_y_valid", 32'(Y_VALID), 32'd0);
      check("rst_occ", 32'(OCC), 32'd0);
      check("rst_y", 32'(Y), 32'd0);
      RN = 1'b1;
      #1;
      check("rst_a_ready", 32'(A_READY), 32'd1);

      // Back-to-back stream, never stalled: exact latency and consecutive outputs.
      seq[0] = 8'h00; seq[1] = 8'h5A; seq[2] = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         bus_cycle(1'b1, seq[i], 1'b1, 1'b0, '0, 1'b1, acc);
         check("stream_accept", 32'(acc), 32'd1);
      end
      drain();

      // Stall: only DEPTH words fit, the next enters as the head drains.
      for (int i = 0; i <= int'(DEPTH); i++) words[i] = WIDTH'($urandom);
      idx = 0;
      for (int i = 0; i < int'(DEPTH) + 3; i++) begin
         bus_cycle(1'b1, words[idx], 1'b0, 1'b0, '0, 1'b0, acc);
         if (acc) idx++;
      end
      check("stall_accepted", 32'(idx), 32'(DEPTH));
      check("stall_occ_full", 32'(OCC), 32'(DEPTH));
      check("stall_a_ready", 32'(A_READY), 32'd0);
      bus_cycle(1'b1, words[idx], 1'b1, 1'b0, '0, 1'b0, acc);
      check("full_drain_accept", 32'(acc), 32'd1);
      bus_cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, acc);
      check("occ_stays_full", 32'(OCC), 32'(DEPTH));
      drain();

      // Y_READY toggling with A_VALID held high.
      sent = 0;
      t    = 0;
      while (sent < 20 && t < 200) begin
         bus_cycle(1'b1, WIDTH'($urandom), (t % 2) == 0, 1'b0, '0, 1'b0, acc);
         if (acc) sent++;
         t++;
      end
      check("toggle_sent", 32'(sent), 32'd20);
      drain();

`ifdef GF180_OSU_INVPIPE_POL_EN
      // Word on the load edge keeps the old mask; the next uses the new one.
      bus_cycle(1'b1, 8'hAA, 1'b1, 1'b1, 8'h0F, 1'b1, acc);
      bus_cycle(1'b1, 8'h33, 1'b1, 1'b0, '0, 1'b1, acc);
      drain();
`endif

      // Random traffic, including random mask loads when the mask is present.
      for (int i = 0; i < 400; i++) begin
         bus_cycle($urandom_range(0, 3) != 0, WIDTH'($urandom), $urandom_range(0, 2) != 0,
                   $urandom_range(0, 15) == 0, WIDTH'($urandom), 1'b0, acc);
      end
      drain();

      // Asynchronous reset with two words in flight.
      bus_cycle(1'b1, 8'h12, 1'b0, 1'b1, 8'h0F, 1'b0, acc);
      bus_cycle(1'b1, 8'h34, 1'b0, 1'b0, '0, 1'b0, acc);
      for (int i = 0; i < 3; i++) bus_cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, acc);
      check("pre_reset_occ", 32'(OCC), 32'd2);
      @(negedge CLK);
      #3;
      RN = 1'b0;
      #1;
      check("async_y_valid", 32'(Y_VALID), 32'd0);
      check("async_occ", 32'(OCC), 32'd0);
      check("async_y", 32'(Y), 32'd0);
      q.delete();
      mask_m = '1;
      #3;
      RN = 1'b1;
      #1;
      check("post_reset_a_ready", 32'(A_READY), 32'd1);
      bus_cycle(1'b1, 8'h3C, 1'b1, 1'b0, '0, 1'b1, acc);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
